// File: rtl/reg_dump_if.sv
// reg_dump_if: register file read ports plus the valid/ready dump stream
interface reg_dump_if;
  logic [4:0] rfAddr1;
  logic [4:0] rfAddr2;
  logic [31:0] rfData1;
  logic [31:0] rfData2;
  logic [31:0] outData;
  logic [4:0] outAddr;
  logic outValid;
  logic outReady;
  logic outLast;
  modport master (
    output rfAddr1, rfAddr2, outData, outAddr, outValid, outLast,
    input  rfData1, rfData2, outReady
  );
  modport slave (
    input  rfAddr1, rfAddr2, outData, outAddr, outValid, outLast,
    output rfData1, rfData2, outReady
  );
endinterface

// File: rtl/reg_dump_unit.sv
// reg_dump_unit: streams register words START_ADDR..END_ADDR two at a time over valid/ready
// define REG_DUMP_CHECKSUM_EN to append an XOR checksum word carrying outLast
module reg_dump_unit #(
  parameter int START_ADDR = 0,
  parameter int END_ADDR = 31
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  reg_dump_if.master bus
);
`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, SEND0, SEND1, CSUM, FIN} state_t;
  localparam state_t FINISH = CSUM;
  logic [31:0] csum;
`else
  typedef enum logic [2:0] {IDLE, FETCH, SEND0, SEND1, FIN} state_t;
  localparam state_t FINISH = FIN;
`endif
  localparam logic [4:0] SA = 5'(START_ADDR);
  localparam logic [4:0] EA = 5'(END_ADDR);
  state_t st, nxt;
  logic [4:0] ptr, ptr1;
  logic [31:0] buf0, buf1;
  logic pair_valid, xfer;
  assign ptr1 = ptr + 5'd1;
  assign xfer = bus.outValid & bus.outReady;
  always_ff @(posedge clk)
    if (rst) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE: nxt = start ? FETCH : IDLE;
      FETCH: nxt = SEND0;
      SEND0: nxt = !xfer ? SEND0 : pair_valid ? SEND1 : FINISH;
      SEND1: nxt = !xfer ? SEND1 : ptr1 == EA ? FINISH : FETCH;
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: nxt = xfer ? FIN : CSUM;
`endif
      FIN: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = st != IDLE;
    done = st == FIN;
    bus.rfAddr1 = ptr;
    bus.rfAddr2 = ptr1;
    bus.outAddr = st == SEND0 ? ptr : st == SEND1 ? ptr1 : 5'd0;
`ifdef REG_DUMP_CHECKSUM_EN
    bus.outValid = st == SEND0 || st == SEND1 || st == CSUM;
    bus.outData = st == SEND0 ? buf0 : st == SEND1 ? buf1 : st == CSUM ? csum : 32'd0;
    bus.outLast = st == CSUM;
`else
    bus.outValid = st == SEND0 || st == SEND1;
    bus.outData = st == SEND0 ? buf0 : st == SEND1 ? buf1 : 32'd0;
    bus.outLast = (st == SEND0 && ptr == EA) || (st == SEND1 && ptr1 == EA);
`endif
  end
  always_ff @(posedge clk)
    if (rst) begin
      ptr <= 5'd0;
      buf0 <= 32'd0;
      buf1 <= 32'd0;
      pair_valid <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum <= 32'd0;
`endif
    end else begin
      if (st == IDLE && start) ptr <= SA;
      if (st == FETCH) begin
        buf0 <= bus.rfData1;
        buf1 <= bus.rfData2;
        pair_valid <= ptr < EA;
      end
      if (st == SEND1 && xfer && ptr1 != EA) ptr <= ptr + 5'd2;
`ifdef REG_DUMP_CHECKSUM_EN
      if (st == IDLE && start) csum <= 32'd0;
      else if (xfer && (st == SEND0 || st == SEND1)) csum <= csum ^ (st == SEND0 ? buf0 : buf1);
`endif
    end
endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit: randomized dumps on a default and a 3..7 instance, checked against a word-list model
module tb_reg_dump_unit;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CSUM_EN = 1;
`else
  localparam int CSUM_EN = 0;
`endif
  typedef struct packed {logic [4:0] a; logic [31:0] d; logic l;} word_t;
  logic clk, rst, start_a, start_b, busy_a, busy_b, done_a, done_b, ready, sel;
  logic [31:0] rf [32];
  int checks = 0, failures = 0, cyc = 0;
  int done_cnt, done_cyc, first_cyc, stall_obs;
  word_t got_q[$];
  logic stalled = 0;
  logic [31:0] h_data;
  logic [4:0] h_addr;
  logic h_last;
  reg_dump_if ia();
  reg_dump_if ib();
  reg_dump_unit ua (.clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .bus(ia));
  reg_dump_unit #(.START_ADDR(3), .END_ADDR(7)) ub (.clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .bus(ib));
  assign ia.rfData1 = rf[ia.rfAddr1];
  assign ia.rfData2 = rf[ia.rfAddr2];
  assign ib.rfData1 = rf[ib.rfAddr1];
  assign ib.rfData2 = rf[ib.rfAddr2];
  assign ia.outReady = ready;
  assign ib.outReady = ready;
  logic m_valid, m_last, m_busy, m_done;
  logic [31:0] m_data;
  logic [4:0] m_addr;
  assign m_valid = sel ? ib.outValid : ia.outValid;
  assign m_last = sel ? ib.outLast : ia.outLast;
  assign m_data = sel ? ib.outData : ia.outData;
  assign m_addr = sel ? ib.outAddr : ia.outAddr;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (rst) stalled = 0;
    else begin
      if (m_valid && stalled) begin
        check("hold_data", m_data, h_data);
        check("hold_addr", m_addr, h_addr);
        check("hold_last", m_last, h_last);
      end
      if (m_valid && first_cyc < 0) first_cyc = cyc;
      if (m_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (m_valid && !ready && m_addr == 5'd3) stall_obs++;
      if (m_valid && ready) got_q.push_back('{m_addr, m_data, m_last});
      stalled = m_valid && !ready;
      h_data = m_data;
      h_addr = m_addr;
      h_last = m_last;
    end
  task automatic run_dump(input int s, input int e, input int mode);
    word_t exp_q[$];
    logic [31:0] x = 0;
    int k, n = 0, stall_left = 5, w = e - s + 1;
    for (int i = s; i <= e; i++) begin
      exp_q.push_back('{i[4:0], rf[i], (i == e) && CSUM_EN == 0});
      x ^= rf[i];
    end
    if (CSUM_EN != 0) exp_q.push_back('{5'd0, x, 1'b1});
    got_q.delete();
    done_cnt = 0;
    first_cyc = -1;
    stall_obs = 0;
    @(posedge clk); #1;
    ready = 1;
    if (sel) start_b = 1; else start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    start_b = 0;
    k = cyc;
    @(negedge clk);
    check("fetch_busy", m_busy, 1);
    check("fetch_valid", m_valid, 0);
    while (done_cnt == 0 && n < 600) begin
      @(posedge clk); #1;
      n++;
      ready = mode == 1 ? ($urandom % 3 != 0) : mode == 2 ? !(m_valid && m_addr == 5'd3 && stall_left > 0) : 1'b1;
      if (!ready && mode == 2) stall_left--;
      if (sel) start_b = mode == 1 && m_busy && $urandom % 4 == 0;
      else start_a = mode == 1 && m_busy && $urandom % 4 == 0;
    end
    if (n >= 600) check("timeout", 0, 1);
    start_a = 0;
    start_b = 0;
    ready = 1;
    repeat (3) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("idle_busy", m_busy, 0);
    check("latency", first_cyc, k + 1);
    if (mode == 0) check("done_lat", done_cyc - first_cyc, w + (w + 1) / 2 - 1 + CSUM_EN);
    if (mode == 2) check("stall_cycles", stall_obs, 5);
    check("count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("addr[%0d]", i), got_q[i].a, exp_q[i].a);
      check($sformatf("data[%0d]", i), got_q[i].d, exp_q[i].d);
      check($sformatf("last[%0d]", i), got_q[i].l, exp_q[i].l);
    end
  endtask
  initial begin
    int n;
    rst = 1;
    start_a = 0;
    start_b = 0;
    ready = 1;
    sel = 0;
    first_cyc = 0;
    done_cnt = 0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", ia.outValid, 0);
    check("rst_last", ia.outLast, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_data", ia.outData, 0);
    check("rst_addr", ia.outAddr, 0);
    check("rst_rfaddr1", ia.rfAddr1, 0);
    check("rst_rfaddr2", ia.rfAddr2, 1);
    @(posedge clk); #1;
    rst = 0;
    run_dump(0, 31, 0);
    for (int i = 0; i < 32; i++) rf[i] = 32'h1 << i;
    run_dump(0, 31, 0);
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    run_dump(0, 31, 2);
    repeat (3) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      run_dump(0, 31, 1);
    end
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    got_q.delete();
    @(posedge clk); #1;
    start_a = 1;
    @(posedge clk); #1;
    start_a = 0;
    n = 0;
    while (got_q.size() < 10 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("pre_rst_words", got_q.size(), 10);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("midrst_valid", ia.outValid, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_last", ia.outLast, 0);
    run_dump(0, 31, 1);
    sel = 1;
    run_dump(3, 7, 0);
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    run_dump(3, 7, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_dump_unit.md
REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

Interface
REQ-001 Parameter START_ADDR, default 0: first register index dumped; legal range 0..31, must not exceed END_ADDR.
REQ-002 Parameter END_ADDR, default 31: last register index dumped; legal range 0..31.
REQ-003 Port clk  in  1: the single clock; all state updates on the rising edge.
REQ-004 Port rst  in  1: reset, synchronous and active-high.
REQ-005 Port start  in  1: request a dump; sampled only in IDLE.
REQ-006 Port rfAddr1  out  5: register file read address, port 1.
REQ-007 Port rfAddr2  out  5: register file read address, port 2.
REQ-008 Port rfData1  in  32: register file read data for rfAddr1, combinational.
REQ-009 Port rfData2  in  32: register file read data for rfAddr2, combinational.
REQ-010 Port outData  out  32: dumped word.
REQ-011 Port outAddr  out  5: register index of outData; 0 for the checksum word.
REQ-012 Port outValid  out  1: outData/outAddr/outLast valid.
REQ-013 Port outReady  in  1: sink accepts the word; transfer occurs when outValid and outReady are both high at a rising edge.
REQ-014 Port outLast  out  1: marks the final word of a dump.
REQ-015 Port busy  out  1: high in every state except IDLE.
REQ-016 Port done  out  1: one-cycle pulse when a dump completes.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, SEND0, SEND1, CSUM and FIN.
- IDLE: start=1 -> ptr<=START_ADDR, clear checksum, go to FETCH.
- FETCH: drive rfAddr1=ptr, rfAddr2=ptr+1; capture rfData1->buf0 and rfData2->buf1; pairValid<=(ptr<END_ADDR); go to SEND0.
- SEND0: outData=buf0, outAddr=ptr. On transfer: if pairValid, go to SEND1; else finish.
- SEND1: outData=buf1, outAddr=ptr+1. On transfer: if ptr+1==END_ADDR, finish; else ptr<=ptr+2 and go to FETCH.
- Finish: go to CSUM if the macro in REQ-028 is defined, otherwise go to FIN.
- CSUM: outData=checksum, outAddr=0, outLast=1. On transfer, go to FIN.
- FIN: done=1 for one cycle, then go to IDLE.
REQ-018 outValid SHALL be high exactly in SEND0, SEND1 and CSUM.
REQ-019 Latency: start sampled at edge k -> FETCH during cycle k+1 -> first outValid during cycle k+2.
REQ-020 While outValid=1 and outReady=0, outData, outAddr and outLast SHALL hold stable, and the state SHALL not advance.
REQ-021 Checksum SHALL be the 32-bit XOR of every transferred register word, updated on each register-word transfer.
REQ-022 Without the checksum feature, outLast SHALL be high with the word whose outAddr==END_ADDR.
REQ-023 start asserted while busy=1 SHALL be ignored; no queuing.
REQ-024 ptr+1 SHALL be computed in 5 bits; when ptr=31, pairValid=0, so rfAddr2 wrapping to 0 is harmless.
REQ-025 A register file write in the cycle before FETCH SHALL be visible in the dump; captured words SHALL not change after FETCH.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, even mid-dump. It SHALL also set ptr, buf0, buf1, checksum and pairValid to 0.
REQ-027 After reset, outputs SHALL be: outValid=0, outLast=0, busy=0, done=0, outData=0, outAddr=0, rfAddr1=0, rfAddr2=1. No partial transfer is allowed.

Configuration
REQ-028 Macro REG_DUMP_CHECKSUM_EN:
- Defined: CSUM state present; the checksum word is appended after END_ADDR with outLast=1.
- Undefined: no CSUM state and no checksum register; REQ-022 applies.

Verification
REQ-029 Defaults, regs r[i]=0x100+i, outReady=1, start pulse -> 32 words, outAddr 0..31, data 0x100..0x11F, outLast on addr 31 (macro off), done about 48 cycles after first outValid.
REQ-030 r[i]=1<<i, macro on -> 33rd word outData=0xFFFFFFFF, outAddr=0, outLast=1, then done pulse.
REQ-031 Backpressure: outReady=0 for 5 cycles while word addr 3 is presented -> outData=0x103 and outAddr=3 held stable, no word lost or duplicated.
REQ-032 START_ADDR=3, END_ADDR=7 -> words 3..7 only; word 7 via SEND0 with pairValid=0; outLast on 7.
REQ-033 rst after 10 transfers -> next cycle outValid=0, busy=0. A new start restarts at START_ADDR with checksum cleared.
REQ-034 start re-pulsed while busy -> ignored; exactly one done pulse per accepted start.
